sr_window_sequencer: RTL
========================

Name: sr_window_sequencer

Overview:
Controller for the three-stage pixel shift-register chain in the downsampling datapath. It walks the source image in raster order and fetches pixels from image memory with a req/ack handshake. It pulses SR_en once per fetched pixel and, every STRIDE pixels, presents a valid 3-tap window (SR3/SR2/SR1 = cols c-2/c-1/c) to the filter/ALU with a valid/ready handshake. It also steps rows by STRIDE and signals completion.

Parameters:
IMG_WIDTH, 256, source pixels per row; legal range is 3 or more.
IMG_HEIGHT, 256, source rows; legal range is 1 or more.
STRIDE, 2, horizontal and vertical decimation factor; legal range is 1..3.
ADDR_W, 16, memory address width; must satisfy IMG_WIDTH*IMG_HEIGHT <= 2^ADDR_W.

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse that begins a frame; ignored while busy=1
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the frame completes
mem_req  out  1  read request to image memory
mem_addr  out  ADDR_W  pixel address, equal to row*IMG_WIDTH+col; held stable while mem_req=1
mem_ack  in  1  memory has driven the pixel onto the shared bus; the bus stays valid until the next mem_req
SR_en  out  1  shift enable for the shift-register chain
win_valid  out  1  the shift registers hold a complete window
win_ready  in  1  the downstream consumer accepts the window
out_col  out  ADDR_W  output-image column of the current window
out_row  out  ADDR_W  output-image row of the current window

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE; busy, done, mem_req, SR_en and win_valid are 0; mem_addr, out_col and out_row are 0; all counters are 0. Reset mid-frame abandons the frame with no done pulse.
- States: IDLE, FETCH, SHIFT, EMIT, FIN.
- IDLE: start=1 sets row=0, col=0, fill=0, out_row=0, out_col=0, then goes to FETCH next cycle.
- FETCH: mem_req=1 and mem_addr=row*IMG_WIDTH+col, both registered. mem_ack=1 moves to SHIFT. mem_ack is ignored in every other state.
- SHIFT: mem_req=0, SR_en=1 for exactly one cycle.
  - fill saturates at 3.
  - If col>=2 and (col-2) mod STRIDE == 0, go to EMIT.
  - Otherwise col+=1 and go to FETCH.
- Minimum cost per pixel is 2 cycles (ack arriving in the same cycle as req).
- EMIT: win_valid=1, held with out_col and out_row stable until win_ready=1. SR_en=0 throughout EMIT, so the window is frozen.
  - On the handshake, out_col+=1.
  - If col+STRIDE <= IMG_WIDTH-1: col+=1, go to FETCH.
  - Else (end of row; trailing pixels are never fetched): col=0, fill=0, out_col=0, row+=STRIDE, out_row+=1. If row >= IMG_HEIGHT go to FIN, else go to FETCH.
- FIN: done=1 for one cycle, busy=1, then go to IDLE.
- Windows per row: floor((IMG_WIDTH-3)/STRIDE)+1. Output rows: ceil(IMG_HEIGHT/STRIDE).
- Address arithmetic is unsigned ADDR_W. The row base is an accumulator incremented by STRIDE*IMG_WIDTH; no multiplier is used.
- The fill counter guarantees no window is emitted until 3 pixels of the current row have been shifted in. The previous row's residue is always flushed.
- start during busy has no effect. start in the same cycle that FIN returns to IDLE is ignored.

Decomposition:
- Shared package: the state encoding (localparams IDLE..FIN) and the derived constants WIN_PER_ROW, OUT_ROWS and ROW_STEP=STRIDE*IMG_WIDTH. These are shared with the ALU controller and the testbench.
- One natural sub-module, raster_addr_gen: the col/row counters, row-base accumulator and end-of-row/end-of-frame flags. The FSM stays in the top level.

Test Plan:
1. IMG_WIDTH=8, IMG_HEIGHT=4, STRIDE=2, mem_ack tied 1, win_ready tied 1 -> addresses 0..6 then 16..22; 14 SR_en pulses; 6 windows with (out_row,out_col) = (0,0..2),(1,0..2); window pixels = cols {0,1,2},{2,3,4},{4,5,6}; single done pulse; busy low afterwards.
2. Same configuration, mem_ack delayed 0..3 random cycles -> mem_addr stable while mem_req=1; exactly one SR_en per ack; window contents identical to scenario 1.
3. win_ready held 0 for 5 cycles at the first window -> win_valid, out_col and out_row stable; no SR_en and no mem_req during the stall; the sequence resumes correctly.
4. IMG_WIDTH=3, IMG_HEIGHT=3, STRIDE=3 -> one window (cols 0,1,2 of row 0), addresses 0,1,2 only; done follows.
5. reset_n dropped mid-row -> all outputs 0 asynchronously, no done; a fresh start re-runs the frame from address 0 correctly.
6. start pulsed while busy -> ignored; exactly one done for the frame in progress.

Source files
------------

// File: rtl/sr_window_sequencer_pkg.sv
// Shared types and derived geometry for the downsampling window sequencer.
// Imported by the sequencer, its address generator, the ALU controller and the bench.
package sr_window_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SHIFT = 3'd2,
    EMIT  = 3'd3,
    FIN   = 3'd4
  } state_t;

  localparam int DEF_IMG_WIDTH  = 256;
  localparam int DEF_IMG_HEIGHT = 256;
  localparam int DEF_STRIDE     = 2;
  localparam int DEF_ADDR_W     = 16;

  function automatic int win_per_row(input int w, input int s);
    return (w - 3) / s + 1;
  endfunction

  function automatic int out_rows(input int h, input int s);
    return (h + s - 1) / s;
  endfunction

  function automatic int row_step(input int w, input int s);
    return w * s;
  endfunction

  localparam int WIN_PER_ROW = win_per_row(DEF_IMG_WIDTH, DEF_STRIDE);
  localparam int OUT_ROWS    = out_rows(DEF_IMG_HEIGHT, DEF_STRIDE);
  localparam int ROW_STEP    = row_step(DEF_IMG_WIDTH, DEF_STRIDE);

endpackage

// File: rtl/sr_window_sequencer_if.sv
// Control/handshake bundle between the window sequencer, image memory and the filter/ALU.
// master = sequencer side, slave = environment (memory + consumer + frame control).
interface sr_window_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic              start;
    logic              busy;
    logic              done;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic              SR_en;
    logic              win_valid;
    logic              win_ready;
    logic [ADDR_W-1:0] out_col;
    logic [ADDR_W-1:0] out_row;

    modport master (
        input  start, mem_ack, win_ready,
        output busy, done, mem_req, mem_addr, SR_en, win_valid, out_col, out_row
    );

    modport slave (
        output start, mem_ack, win_ready,
        input  busy, done, mem_req, mem_addr, SR_en, win_valid, out_col, out_row
    );
endinterface

// File: rtl/sr_window_sequencer_raster_addr_gen.sv
// Raster walker: column/row counters, row-base accumulator, fill level and the
// window / end-of-row / end-of-frame decisions the sequencer FSM branches on.
module raster_addr_gen
    import sr_window_sequencer_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int STRIDE     = DEF_STRIDE,
    parameter int ADDR_W     = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_clear,
    input  logic              i_shift,
    input  logic              i_col_inc,
    input  logic              i_row_next,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_emit_pt,
    output logic              o_eol,
    output logic              o_eof
);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(row_step(IMG_WIDTH, STRIDE));
    localparam int CW = ADDR_W + 2;

    logic [ADDR_W-1:0] r_col;
    logic [ADDR_W-1:0] r_row;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_fill;
    logic [CW-1:0]     w_col_ext;
    logic              w_phase_ok;

    // The address is tracked incrementally alongside col so no multiplier is needed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_col  <= '0;
            r_row  <= '0;
            r_base <= '0;
            r_addr <= '0;
            r_fill <= '0;
        end else if (i_clear) begin
            r_col  <= '0;
            r_row  <= '0;
            r_base <= '0;
            r_addr <= '0;
            r_fill <= '0;
        end else if (i_row_next) begin
            r_col  <= '0;
            r_fill <= '0;
            r_row  <= r_row + ADDR_W'(STRIDE);
            r_base <= r_base + STEP;
            r_addr <= r_base + STEP;
        end else begin
            if (i_shift && r_fill != 2'd3) r_fill <= r_fill + 2'd1;
            if (i_col_inc) begin
                r_col  <= r_col + 1'b1;
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    assign w_col_ext  = CW'(r_col);
    assign w_phase_ok = ((w_col_ext - CW'(2)) % CW'(STRIDE)) == '0;

    // Sampled during SHIFT, before this pixel bumps fill: fill>=2 means 3 are in.
    assign o_emit_pt = (w_col_ext >= CW'(2)) && w_phase_ok && (r_fill >= 2'd2);
    assign o_eol     = (w_col_ext + CW'(STRIDE)) > CW'(IMG_WIDTH - 1);
    assign o_eof     = (CW'(r_row) + CW'(STRIDE)) >= CW'(IMG_HEIGHT);
    assign o_addr    = r_addr;
endmodule

// File: rtl/sr_window_sequencer.sv
// Sequencer for the 3-tap pixel shift-register chain: fetches pixels in raster order,
// pulses SR_en per pixel and hands a window to the filter every STRIDE pixels.
module sr_window_sequencer
    import sr_window_sequencer_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int STRIDE     = DEF_STRIDE,
    parameter int ADDR_W     = DEF_ADDR_W
) (
    input  logic                  clock,
    input  logic                  reset_n,
    sr_window_sequencer_if.master bus
);
    state_t            r_state;
    state_t            w_nxt;
    logic [1:0]        r_rst_sync;
    logic              w_rst_n;
    logic              r_busy;
    logic              r_done;
    logic              r_mem_req;
    logic              r_sr_en;
    logic              r_win_valid;
    logic [ADDR_W-1:0] r_out_col;
    logic [ADDR_W-1:0] r_out_row;
    logic              w_clear;
    logic              w_shift;
    logic              w_col_inc;
    logic              w_row_next;
    logic              w_win_hs;
    logic [ADDR_W-1:0] w_addr;
    logic              w_emit_pt;
    logic              w_eol;
    logic              w_eof;

    // Reset asserts immediately, releases on a clock edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= '0;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    raster_addr_gen #(
        .IMG_WIDTH (IMG_WIDTH),
        .IMG_HEIGHT(IMG_HEIGHT),
        .STRIDE    (STRIDE),
        .ADDR_W    (ADDR_W)
    ) u_addr (
        .clock     (clock),
        .reset_n   (w_rst_n),
        .i_clear   (w_clear),
        .i_shift   (w_shift),
        .i_col_inc (w_col_inc),
        .i_row_next(w_row_next),
        .o_addr    (w_addr),
        .o_emit_pt (w_emit_pt),
        .o_eol     (w_eol),
        .o_eof     (w_eof)
    );

    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= IDLE;
        else          r_state <= w_nxt;
    end

    always_comb begin
        w_nxt      = r_state;
        w_clear    = 1'b0;
        w_shift    = 1'b0;
        w_col_inc  = 1'b0;
        w_row_next = 1'b0;
        w_win_hs   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_clear = 1'b1;
                    w_nxt   = FETCH;
                end
            end
            FETCH: begin
                if (bus.mem_ack) w_nxt = SHIFT;
            end
            SHIFT: begin
                w_shift = 1'b1;
                if (w_emit_pt) begin
                    w_nxt = EMIT;
                end else begin
                    w_col_inc = 1'b1;
                    w_nxt     = FETCH;
                end
            end
            EMIT: begin
                if (bus.win_ready) begin
                    w_win_hs = 1'b1;
                    if (!w_eol) begin
                        w_col_inc = 1'b1;
                        w_nxt     = FETCH;
                    end else begin
                        // Trailing pixels past the last full window are skipped.
                        w_row_next = 1'b1;
                        w_nxt      = w_eof ? FIN : FETCH;
                    end
                end
            end
            FIN:     w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_sr_en     <= 1'b0;
            r_win_valid <= 1'b0;
            r_out_col   <= '0;
            r_out_row   <= '0;
        end else begin
            r_busy      <= (w_nxt != IDLE);
            r_done      <= (w_nxt == FIN);
            r_mem_req   <= (w_nxt == FETCH);
            r_sr_en     <= (w_nxt == SHIFT);
            r_win_valid <= (w_nxt == EMIT);
            if (w_clear) begin
                r_out_col <= '0;
                r_out_row <= '0;
            end else if (w_win_hs) begin
                if (w_row_next) begin
                    r_out_col <= '0;
                    r_out_row <= r_out_row + 1'b1;
                end else begin
                    r_out_col <= r_out_col + 1'b1;
                end
            end
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_addr  = w_addr;
    assign bus.SR_en     = r_sr_en;
    assign bus.win_valid = r_win_valid;
    assign bus.out_col   = r_out_col;
    assign bus.out_row   = r_out_row;
endmodule
